nes_pad_reader: RTL and testbench

- Producer side of the processor's `controller_data[7:0]` input.
- Drives a serial NES-style pad, shifts in the 8 button bits and presents them as a stable, active-high parallel byte.
- Raises a one-cycle change interrupt when the button state differs from the previously published value.
- Sits beside `mips` in the top level, on the same clock, wired between the pad pins and `controller_data` / `interrupts`.

---
 rtl/nes_pad_reader_pkg.sv | 25 ++
 rtl/nes_pad_reader_if.sv | 27 ++
 rtl/nes_pad_reader_sync2.sv | 23 ++
 rtl/nes_pad_reader.sv | 126 ++++++++++++
 tb/tb_nes_pad_reader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nes_pad_reader_pkg.sv
// Shared types and constants for the NES pad reader: FSM states and button bit positions.
package nes_pad_pkg;

    localparam int NUM_BITS = 8;
    localparam int IDX_W    = $clog2(NUM_BITS);

    // Bit positions of each button in the published, active-high byte.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        LOW    = 3'd2,
        HIGH   = 3'd3,
        COMMIT = 3'd4
    } state_t;

endpackage

// File: rtl/nes_pad_reader_if.sv
// Pad pins plus the published button byte; master is the reader, slave is the pad/consumer side.
interface nes_pad_reader_if;
    import nes_pad_pkg::*;

    logic                poll_en;
    logic                nes_data;
    logic                nes_latch;
    logic                nes_clk;
    logic [NUM_BITS-1:0] controller_data;
    logic                data_valid;
    logic                cnt_chg;
    state_t              state;

    // data_valid is a one-cycle strobe with no back-pressure: controller_data is
    // valid and stable from that cycle until the next strobe; cnt_chg only
    // ever rises together with data_valid.
    modport master (
        input  poll_en, nes_data,
        output nes_latch, nes_clk, controller_data, data_valid, cnt_chg, state
    );

    modport slave (
        output poll_en, nes_data,
        input  nes_latch, nes_clk, controller_data, data_valid, cnt_chg, state
    );

endinterface

// File: rtl/nes_pad_reader_sync2.sv
// Two-flop synchronizer with a selectable reset value for asynchronous pad inputs.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls a serial NES pad, shifts in 8 active-low buttons and publishes them active-high,
// flagging when the published value changes.
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int LATCH_CYC = 150,
    parameter int HALF_CYC  = 75,
    parameter int POLL_CYC  = 416667,
    parameter int CNT_W     = 19
) (
    input  logic             clk,
    input  logic             reset,
    nes_pad_reader_if.master bus
);

    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYC - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

    logic                sd;
    logic [CNT_W-1:0]    poll_cnt;
    logic [CNT_W-1:0]    phase;
    logic [IDX_W-1:0]    idx;
    logic [NUM_BITS-1:0] shift;
    state_t              state;
    logic                latch_q;
    logic                nclk_q;
    logic [NUM_BITS-1:0] data_q;
    logic                dv_q;
    logic                chg_q;
    logic                frame_start;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.nes_data),
        .q     (sd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  poll_cnt <= '0;
        else if (poll_cnt == POLL_LAST) poll_cnt <= '0;
        else                         poll_cnt <= poll_cnt + 1'b1;
    end

    // A tick that lands while a frame is running or polling is disabled is simply lost.
    assign frame_start = (poll_cnt == '0) && (state == IDLE) && bus.poll_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            phase   <= '0;
            idx     <= '0;
            shift   <= '1;
            latch_q <= 1'b0;
            nclk_q  <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            chg_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= LATCH;
                        latch_q <= 1'b1;
                        phase   <= '0;
                        idx     <= '0;
                        shift   <= '1;
                    end
                end
                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        state   <= LOW;
                        latch_q <= 1'b0;
                        phase   <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LOW: begin
                    // Sample at the end of the low half, when the pad output has settled longest.
                    if (phase == HALF_LAST) begin
                        phase      <= '0;
                        shift[idx] <= sd;
                        if (idx == IDX_LAST) begin
                            state <= COMMIT;
                        end else begin
                            state  <= HIGH;
                            nclk_q <= 1'b1;
                            idx    <= idx + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase == HALF_LAST) begin
                        state  <= LOW;
                        nclk_q <= 1'b0;
                        phase  <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                COMMIT: begin
                    data_q <= ~shift;
                    dv_q   <= 1'b1;
                    chg_q  <= (~shift != data_q);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.nes_latch       = latch_q;
    assign bus.nes_clk         = nclk_q;
    assign bus.controller_data = data_q;
    assign bus.data_valid      = dv_q;
    assign bus.cnt_chg         = chg_q;
    assign bus.state           = state;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural pad model, frame timing monitor, table and random frames.
module tb_nes_pad_reader;
  import nes_pad_pkg::*;

  localparam int LATCH_CYC = 4;
  localparam int HALF_CYC  = 2;
  localparam int POLL_CYC  = 100;
  localparam int CNT_W     = 7;
  localparam int FRAME_DV  = 36;   // negedges from frame start tick to visible data_valid
  localparam int BUDGET    = 300;

  logic clk;
  logic reset;

  nes_pad_reader_if bus ();

  nes_pad_reader #(
    .LATCH_CYC (LATCH_CYC),
    .HALF_CYC  (HALF_CYC),
    .POLL_CYC  (POLL_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // pad model controls
  bit         pad_conn = 1'b0;
  bit         pad_glitch = 1'b0;
  logic [7:0] pad_btn = 8'h00;

  // monitor state
  int cyc = 0;
  int overlap = 0;
  int latch_rises[$];
  int latch_hi_cnt = 0;
  int frame_clk_rises = 0;
  int hi_run = 0, lo_run = 0;
  int hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
  int dv_cnt = 0;
  logic prev_latch = 1'b0, prev_nclk = 1'b0;

  // scoreboard
  logic [7:0] exp_q[$];
  logic       exp_chg_q[$];
  logic [7:0] last_pub = 8'h00;

  typedef struct {
    bit         conn;
    logic [7:0] btn;
    bit         glitch;
    logic [7:0] exp_data;
    logic       exp_chg;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Pad: latch loads button 0, each rising nes_clk advances to the next button; line is active-low.
  initial begin
    int  ptr;
    bit  pad_prev_clk;
    bit  rise;
    ptr = 0;
    pad_prev_clk = 1'b0;
    bus.nes_data = 1'b1;
    forever begin
      @(negedge clk);
      rise = 1'b0;
      if (bus.nes_latch) ptr = 0;
      else if (bus.nes_clk && !pad_prev_clk) begin
        rise = 1'b1;
        if (ptr < 8) ptr++;
      end
      pad_prev_clk = bus.nes_clk;
      if (!pad_conn) bus.nes_data = 1'b1;
      else if (rise && pad_glitch) bus.nes_data = 1'($urandom_range(0, 1));
      else bus.nes_data = (ptr < 8) ? ~pad_btn[ptr] : 1'b1;
    end
  end

  // Timing monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.nes_latch && bus.nes_clk) overlap++;
      if (bus.nes_latch && !prev_latch) begin
        latch_rises.push_back(cyc);
        frame_clk_rises = 0;
      end
      if (bus.nes_latch) begin
        latch_hi_cnt++;
        lo_run = 0;
      end
      if (bus.nes_clk) begin
        if (!prev_nclk) begin
          frame_clk_rises++;
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
          lo_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_nclk) begin
          if (hi_run < hi_min) hi_min = hi_run;
          if (hi_run > hi_max) hi_max = hi_run;
          hi_run = 0;
        end
        if (!bus.nes_latch) lo_run++;
      end
      if (bus.data_valid) dv_cnt++;
      prev_latch = bus.nes_latch;
      prev_nclk  = bus.nes_clk;
    end
  end

  task automatic wait_dv(output logic [7:0] d, output logic c, output int t, output bit ok);
    ok = 1'b0; d = 8'h00; c = 1'b0; t = 0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (bus.data_valid) begin
        d = bus.controller_data;
        c = bus.cnt_chg;
        t = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_latch(output int t, output bit ok);
    int n;
    n = latch_rises.size();
    ok = 1'b0; t = 0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (latch_rises.size() > n) begin
        t = latch_rises[$];
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_pulses(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (frame_clk_rises >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] exp_d, input logic exp_c);
    logic [7:0] d;
    logic       c;
    int         t;
    bit         ok;
    wait_dv(d, c, t, ok);
    check({name, "_seen"}, 32'(ok), 32'd1);
    check({name, "_data"}, 32'(d), 32'(exp_d));
    check({name, "_chg"}, 32'(c), 32'(exp_c));
    last_pub = exp_d;
  endtask

  initial begin
    logic [7:0] d;
    logic       c;
    int         t, r, ts, nl;
    bit         ok;

    vecs[0] = '{1'b1, 8'h89, 1'b0, 8'h89, 1'b1};
    vecs[1] = '{1'b1, 8'h89, 1'b0, 8'h89, 1'b0};
    vecs[2] = '{1'b1, 8'h81, 1'b0, 8'h81, 1'b1};
    vecs[3] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1};
    vecs[6] = '{1'b0, 8'hA5, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{1'b1, 8'h10, 1'b0, 8'h10, 1'b1};

    reset = 1'b0;
    bus.poll_en = 1'b1;
    repeat (3) tick();
    check("rst_latch", 32'(bus.nes_latch), 32'd0);
    check("rst_nclk", 32'(bus.nes_clk), 32'd0);
    check("rst_data", 32'(bus.controller_data), 32'h00);
    check("rst_dv", 32'(bus.data_valid), 32'd0);
    check("rst_chg", 32'(bus.cnt_chg), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));

    // First frame, pad line held high
    latch_hi_cnt = 0; dv_cnt = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    reset = 1'b1;
    r = cyc;
    wait_dv(d, c, t, ok);
    check("f1_seen", 32'(ok), 32'd1);
    check("f1_latch_rise", 32'(latch_rises.size() > 0 ? latch_rises[0] : -1), 32'(r + 1));
    check("f1_dv_time", 32'(t), 32'(r + FRAME_DV));
    check("f1_data", 32'(d), 32'h00);
    check("f1_chg", 32'(c), 32'd0);
    check("f1_latch_len", 32'(latch_hi_cnt), 32'(LATCH_CYC));
    check("f1_pulses", 32'(frame_clk_rises), 32'd7);
    check("f1_hi_min", 32'(hi_min), 32'(HALF_CYC));
    check("f1_hi_max", 32'(hi_max), 32'(HALF_CYC));
    check("f1_lo_min", 32'(lo_min), 32'(HALF_CYC));
    check("f1_lo_max", 32'(lo_max), 32'(HALF_CYC));
    repeat (20) tick();
    check("f1_dv_count", 32'(dv_cnt), 32'd1);
    wait_latch(t, ok);
    check("f2_period", 32'(t), 32'(r + 1 + POLL_CYC));
    last_pub = 8'h00;

    // Table-driven frames; pad settings change only while the reader is idle
    wait_dv(d, c, t, ok);
    check("f2_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 9; i++) begin
      pad_conn   = vecs[i].conn;
      pad_btn    = vecs[i].btn;
      pad_glitch = vecs[i].glitch;
      run_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_chg);
    end

    // Random buttons and glitches against the scoreboard
    pad_conn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pad_btn    = 8'($urandom_range(0, 255));
      pad_glitch = 1'($urandom_range(0, 1));
      exp_q.push_back(pad_btn);
      exp_chg_q.push_back(pad_btn != last_pub);
      last_pub = pad_btn;
      wait_dv(d, c, t, ok);
      check($sformatf("rnd%0d_seen", i), 32'(ok), 32'd1);
      check($sformatf("rnd%0d_data", i), 32'(d), 32'(exp_q.pop_front()));
      check($sformatf("rnd%0d_chg", i), 32'(c), 32'(exp_chg_q.pop_front()));
    end

    // poll_en dropped during the third pulse
    pad_glitch = 1'b0;
    pad_btn = 8'h42;
    wait_latch(ts, ok);
    check("pe_start", 32'(ok), 32'd1);
    wait_pulses(3, ok);
    check("pe_pulse3", 32'(ok), 32'd1);
    bus.poll_en = 1'b0;
    run_frame("pe_frame", 8'h42, 8'h42 != last_pub);
    nl = latch_rises.size();
    while (cyc < ts + 150) tick();
    check("pe_no_latch", 32'(latch_rises.size()), 32'(nl));
    bus.poll_en = 1'b1;
    wait_latch(t, ok);
    check("pe_restart", 32'(t), 32'(ts + 2 * POLL_CYC));
    run_frame("pe_after", 8'h42, 1'b0);

    // Reset during the fifth pulse with Up pressed
    pad_btn = 8'h10;
    wait_latch(t, ok);
    check("rm_start", 32'(ok), 32'd1);
    wait_pulses(5, ok);
    check("rm_pulse5", 32'(ok), 32'd1);
    check("rm_pre_nclk", 32'(bus.nes_clk), 32'd1);
    reset = 1'b0;
    #1;
    check("rm_latch", 32'(bus.nes_latch), 32'd0);
    check("rm_nclk", 32'(bus.nes_clk), 32'd0);
    check("rm_data", 32'(bus.controller_data), 32'h00);
    check("rm_dv", 32'(bus.data_valid), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    r = cyc;
    wait_dv(d, c, t, ok);
    check("rm_seen", 32'(ok), 32'd1);
    check("rm_dv_time", 32'(t), 32'(r + FRAME_DV));
    check("rm_result", 32'(d), 32'h10);
    check("rm_chg", 32'(c), 32'd1);

    check("latch_clk_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
